// File: rtl/hellorld_rx.sv
// hellorld_rx: 8N1 UART receiver for the "Hellorld!\r\n" loopback path, with optional message matcher.
// Latency: 2-flop synchronizer, then rx_valid/rx_frame_err one clock after the mid-stop-bit sample edge.
// Backpressure: none; each byte is a one-cycle strobe and must be consumed on the cycle rx_valid is high.
//
// Ports:
//   wb_clk_i        sole clock, rising edge
//   rst_n           asynchronous active-low reset
//   rx_in           serial line, asynchronous, idle high
//   custom_settings bit-period divisor D (one bit = D+1 clocks, D >= 3, stable during a frame)
//   rx_data         last good byte, LSB first on the wire
//   rx_valid        one-cycle pulse when rx_data updates
//   rx_frame_err    one-cycle pulse when the stop bit samples low
//   msg_count       complete "Hellorld!\r\n" messages seen (wraps); 0 unless HELLORLD_RX_MATCH_EN is defined
//
// Build option: define HELLORLD_RX_MATCH_EN to build the message matcher and msg_count register.

module hellorld_rx (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        rx_in,
    input  logic [11:0] custom_settings,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_frame_err,
    output logic [7:0]  msg_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        sync1;
    logic        rs;
    logic [11:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;

    logic        half_hit;
    logic        full_hit;
    logic        cnt_run;
    logic        cnt_clr;
    logic        bit_clr;
    logic        bit_inc;
    logic        shift_en;
    logic        good_stop;
    logic        bad_stop;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rs    <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rs    <= sync1;
        end
    end

    // Start bit is sampled at its midpoint; every later bit one full period on,
    // so all data and stop samples also land mid-bit.
    assign half_hit = (baud_cnt == {1'b0, custom_settings[11:1]});
    assign full_hit = (baud_cnt == custom_settings);

    // FSM state register
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!rs) state_nxt = S_START;
            S_START: if (half_hit) state_nxt = rs ? S_IDLE : S_DATA;
            S_DATA:  if (full_hit && (bit_idx == 3'd7)) state_nxt = S_STOP;
            // Returning to IDLE mid-stop-bit lets a back-to-back start bit be caught.
            S_STOP:  if (full_hit) state_nxt = rs ? S_IDLE : S_BREAK;
            // A held-low line stays here so it produces only one framing error.
            S_BREAK: if (rs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM output logic: datapath controls
    always_comb begin
        cnt_run   = 1'b0;
        cnt_clr   = 1'b0;
        bit_clr   = 1'b0;
        bit_inc   = 1'b0;
        shift_en  = 1'b0;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = !rs;
            end
            S_START: begin
                cnt_run = 1'b1;
                if (half_hit) begin
                    cnt_clr = 1'b1;
                    bit_clr = !rs;
                end
            end
            S_DATA: begin
                cnt_run = 1'b1;
                if (full_hit) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    bit_inc  = 1'b1;
                end
            end
            S_STOP: begin
                cnt_run = 1'b1;
                if (full_hit) begin
                    cnt_clr   = 1'b1;
                    good_stop = rs;
                    bad_stop  = !rs;
                end
            end
            default: begin
                cnt_run = 1'b0;
            end
        endcase
    end

    // Datapath: bit timer, bit index, shift register and registered strobes
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt     <= 12'd0;
            bit_idx      <= 3'd0;
            shift        <= 8'h00;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (cnt_clr) begin
                baud_cnt <= 12'd0;
            end else if (cnt_run) begin
                baud_cnt <= baud_cnt + 12'd1;
            end

            if (bit_clr) begin
                bit_idx <= 3'd0;
            end else if (bit_inc) begin
                bit_idx <= bit_idx + 3'd1;
            end

            // LSB arrives first, so shift in from the top.
            if (shift_en) begin
                shift <= {rs, shift[7:1]};
            end

            if (good_stop) begin
                rx_data <= shift;
            end
            rx_valid     <= good_stop;
            rx_frame_err <= bad_stop;
        end
    end

`ifdef HELLORLD_RX_MATCH_EN

    logic [3:0] match_idx;
    logic [7:0] msg_cnt_q;

    function automatic logic [7:0] exp_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    exp_byte = 8'h48;
            4'd1:    exp_byte = 8'h65;
            4'd2:    exp_byte = 8'h6C;
            4'd3:    exp_byte = 8'h6C;
            4'd4:    exp_byte = 8'h6F;
            4'd5:    exp_byte = 8'h72;
            4'd6:    exp_byte = 8'h6C;
            4'd7:    exp_byte = 8'h64;
            4'd8:    exp_byte = 8'h21;
            4'd9:    exp_byte = 8'h0D;
            4'd10:   exp_byte = 8'h0A;
            default: exp_byte = 8'h00;
        endcase
    endfunction

    // Runs off the registered strobes, so msg_count moves the edge after the
    // final 0x0A's rx_valid cycle. A stray 'H' restarts at index 1 because
    // it is itself the first byte of a new message.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            match_idx <= 4'd0;
            msg_cnt_q <= 8'h00;
        end else if (rx_frame_err) begin
            match_idx <= 4'd0;
        end else if (rx_valid) begin
            if (rx_data == exp_byte(match_idx)) begin
                if (match_idx == 4'd10) begin
                    match_idx <= 4'd0;
                    msg_cnt_q <= msg_cnt_q + 8'd1;
                end else begin
                    match_idx <= match_idx + 4'd1;
                end
            end else if (rx_data == 8'h48) begin
                match_idx <= 4'd1;
            end else begin
                match_idx <= 4'd0;
            end
        end
    end

    assign msg_count = msg_cnt_q;

`else

    assign msg_count = 8'h00;

`endif

endmodule

// File: tb/tb_hellorld_rx.sv
// tb_hellorld_rx: directed bench for hellorld_rx driving 8N1 frames bit by bit.
// Latency: measures edge-to-rx_valid clocks for one frame; other checks are by received byte content.
// Backpressure: none; a negedge monitor captures every rx_valid byte and counts rx_frame_err pulses.

module tb_hellorld_rx;

    logic        wb_clk_i = 1'b0;
    logic        rst_n;
    logic        rx_in;
    logic [11:0] custom_settings;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_frame_err;
    logic [7:0]  msg_count;

`ifdef HELLORLD_RX_MATCH_EN
    localparam int MATCH = 1;
`else
    localparam int MATCH = 0;
`endif

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    logic [7:0] rxq[$];
    logic [7:0] sentq[$];

    hellorld_rx dut (
        .wb_clk_i        (wb_clk_i),
        .rst_n           (rst_n),
        .rx_in           (rx_in),
        .custom_settings (custom_settings),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_frame_err    (rx_frame_err),
        .msg_count       (msg_count)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(negedge wb_clk_i) begin
        if (rx_valid) rxq.push_back(rx_data);
        if (rx_frame_err) ferr_cnt++;
        if (rx_valid && rx_frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All stimulus runs in the phase #1 after a rising edge.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_in = v;
        wait_clks(int'(custom_settings) + 1);
    endtask

    // Leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic send_byte(input logic [7:0] b);
        sentq.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        check({tag, "_avail"}, (rxq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (rxq.size() != 0) check(tag, rxq.pop_front(), exp);
    endtask

    task automatic send_msg(input logic [7:0] m [11]);
        for (int i = 0; i < 11; i++) send_byte(m[i]);
    endtask

    task automatic do_reset();
        rx_in = 1'b1;
        @(negedge wb_clk_i);
        rst_n = 1'b0;
        @(negedge wb_clk_i);
        rst_n = 1'b1;
        wait_clks(3);
    endtask

    logic [7:0] hello [11];
    logic [7:0] bad_msg [11];
    int lat;
    int ferr_base;

    initial begin
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};
        bad_msg = hello;
        bad_msg[4] = 8'h78;
        custom_settings = 12'd15;
        rx_in = 1'b1;
        rst_n = 1'b0;
        wait_clks(2);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_frame_err", rx_frame_err, 1'b0);
        check("rst_msg_count", msg_count, 8'h00);
        @(negedge wb_clk_i);
        rst_n = 1'b1;
        wait_clks(4);

        // 0x48 at D=15: capture edge is edge 1; rx_valid rises 2 sync + 7+1+144 clocks
        // later, i.e. on the 155th rising edge after rx_in falls.
        lat = 0;
        fork
            send_frame(8'h48, 1'b1);
            begin
                for (int n = 1; n <= 400; n++) begin
                    @(posedge wb_clk_i);
                    #2;
                    if (rx_valid && lat == 0) lat = n;
                end
            end
        join
        check("latency_edges", lat, 155);
        expect_byte("b48", 8'h48);
        check("b48_no_ferr", ferr_cnt, 0);

        // 4-clock glitch is rejected at the mid-start-bit check.
        rx_in = 1'b0;
        wait_clks(4);
        rx_in = 1'b1;
        wait_clks(48);
        check("glitch_no_valid", rxq.size(), 0);
        check("glitch_no_ferr", ferr_cnt, 0);
        send_frame(8'hA5, 1'b1);
        wait_clks(8);
        expect_byte("bA5", 8'hA5);

        // Low stop bit plus 100 more low clocks: exactly one framing error.
        send_frame(8'h55, 1'b0);
        wait_clks(100);
        rx_in = 1'b1;
        wait_clks(20);
        check("break_one_ferr", ferr_cnt, 1);
        check("break_no_valid", rxq.size(), 0);
        check("break_data_held", rx_data, 8'hA5);
        send_frame(8'h0D, 1'b1);
        wait_clks(8);
        expect_byte("b0D", 8'h0D);
        check("b0D_no_new_ferr", ferr_cnt, 1);

        // Matcher at D=3, back-to-back frames.
        custom_settings = 12'd3;
        do_reset();
        check("d3_rst_count", msg_count, 8'h00);
        ferr_base = ferr_cnt;
        sentq.delete();
        send_msg(hello);
        send_msg(hello);
        wait_clks(8);
        check("msg_two", msg_count, (MATCH != 0) ? 32'd2 : 32'd0);
        send_byte(8'h48);
        send_msg(hello);
        wait_clks(8);
        check("msg_hh", msg_count, (MATCH != 0) ? 32'd3 : 32'd0);
        send_msg(bad_msg);
        wait_clks(8);
        check("msg_bad", msg_count, (MATCH != 0) ? 32'd3 : 32'd0);
        check("msg_rx_n", rxq.size(), 45);
        begin
            int bad = 0;
            while (rxq.size() != 0 && sentq.size() != 0) begin
                if (rxq.pop_front() !== sentq.pop_front()) bad++;
            end
            check("msg_bytes_match", bad, 0);
        end
        check("msg_no_ferr", ferr_cnt, ferr_base);
        check("msg_last_data", rx_data, 8'h0A);

        // Asynchronous reset in the middle of data bit 4 of a 0x21 frame.
        custom_settings = 12'd15;
        wait_clks(4);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(hello[8][i]);
        rx_in = hello[8][4];
        wait_clks(8);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_rx_data", rx_data, 8'h00);
        check("arst_rx_valid", rx_valid, 1'b0);
        check("arst_frame_err", rx_frame_err, 1'b0);
        check("arst_msg_count", msg_count, 8'h00);
        rx_in = 1'b1;
        wait_clks(20);
        @(negedge wb_clk_i);
        rst_n = 1'b1;
        wait_clks(4);
        rxq.delete();
        send_frame(8'h21, 1'b1);
        wait_clks(8);
        expect_byte("after_arst", 8'h21);
        check("after_arst_extra", rxq.size(), 0);
        check("never_both", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
